// File: rtl/vga_pio_dbuf.sv
// -----------------------------------------------------------------------------
// vga_pio_dbuf
//   Double-buffered Avalon-MM output PIO driving N_CH colour channels for the
//   VGA pipeline. CPU writes land in shadow registers; the live outputs only
//   change on a commit (frame-synchronous, software-forced or immediate), so a
//   colour change never tears in the middle of a frame.
//
//   Optional feature macro: VGA_PIO_DBUF_IRQ_EN
//     defined   : CTRL.IRQ_EN is stored and irq <= DONE & IRQ_EN (registered)
//     undefined : CTRL.IRQ_EN is not stored (reads 0), irq is tied to 0
//
//   Register map (word addresses):
//     0          CTRL   bit0 IMM, bit1 FORCE (write-only pulse), bit2 IRQ_EN
//     1          STATUS bit0 PENDING, bit1 DONE (write 1 to clear)
//     2..N_CH+1  SHADOW[k]
//     other      read 0, writes ignored
//
//   Bus protocol: Avalon-MM slave with no waitrequest. A write happens on every
//   clock edge where chipselect & ~write_n; readdata is combinational from
//   address (zero wait states, zero read latency).
//
//   Ports:
//     clk, reset   system clock, synchronous active-high reset
//     address      word address
//     chipselect   slave select
//     write_n      active-low write strobe
//     writedata    write data (bits [WIDTH-1:0] used for channel data)
//     readdata     read data
//     frame_sync   vsync-derived level, synchronous to clk
//     out_port     live channels, channel k at [k*WIDTH +: WIDTH]
//     irq          commit-done interrupt
// -----------------------------------------------------------------------------
module vga_pio_dbuf #(
  parameter int          WIDTH     = 24,
  parameter int          N_CH      = 4,
  parameter int          ADDR_W    = 4,
  parameter logic [31:0] RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  input  logic                    frame_sync,
  output logic [N_CH*WIDTH-1:0]   out_port,
  output logic                    irq
);

  localparam logic [WIDTH-1:0] RST_CH = RESET_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] shadow [N_CH];
  logic [WIDTH-1:0] live   [N_CH];
  logic             imm;
  logic             pending;
  logic             done;
  logic             fs_q;
  logic             irq_en_rd;

  logic             wr;
  logic             ctrl_sel;
  logic             status_sel;
  logic [N_CH-1:0]  shadow_sel;
  logic             shadow_wr;
  logic             force_wr;
  logic             fs_rise;
  logic             commit;
  logic [WIDTH-1:0] wr_ch;

  // Only part of writedata is meaningful; folding it here keeps every bit
  // accounted for without changing behaviour.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr         = chipselect & ~write_n;
  assign ctrl_sel   = (address == ADDR_W'(0));
  assign status_sel = (address == ADDR_W'(1));
  assign wr_ch      = writedata[WIDTH-1:0];

  always_comb begin
    shadow_sel = '0;
    for (int k = 0; k < N_CH; k++) begin
      shadow_sel[k] = (address == ADDR_W'(k + 2));
    end
  end

  assign shadow_wr = wr & (|shadow_sel);
  assign force_wr  = wr & ctrl_sel & writedata[1];
  assign fs_rise   = frame_sync & ~fs_q;
  // A commit needs something to commit; FORCE or a frame edge with nothing
  // pending is a no-op and leaves DONE alone.
  assign commit    = pending & (fs_rise | force_wr);

`ifdef VGA_PIO_DBUF_IRQ_EN
  logic irq_en;
  assign irq_en_rd = irq_en;
`else
  assign irq_en_rd = 1'b0;
  assign irq       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      imm     <= 1'b0;
      pending <= 1'b0;
      done    <= 1'b0;
      fs_q    <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        shadow[k] <= RST_CH;
        live[k]   <= RST_CH;
      end
`ifdef VGA_PIO_DBUF_IRQ_EN
      irq_en  <= 1'b0;
      irq     <= 1'b0;
`endif
    end else begin
      fs_q <= frame_sync;

      if (wr && ctrl_sel) begin
        imm <= writedata[0];
`ifdef VGA_PIO_DBUF_IRQ_EN
        irq_en <= writedata[2];
`endif
      end

      // The commit reads the pre-write shadow values; an immediate write to
      // the same channel in the same cycle overrides the committed value.
      for (int k = 0; k < N_CH; k++) begin
        if (commit) begin
          live[k] <= shadow[k];
        end
        if (wr && shadow_sel[k]) begin
          shadow[k] <= wr_ch;
          if (imm) begin
            live[k] <= wr_ch;
          end
        end
      end

      // Set beats clear: a write landing with a commit stays pending.
      if (shadow_wr && !imm) begin
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end

      if (commit) begin
        done <= 1'b1;
      end else if (wr && status_sel && writedata[1]) begin
        done <= 1'b0;
      end

`ifdef VGA_PIO_DBUF_IRQ_EN
      irq <= done & irq_en;
`endif
    end
  end

  always_comb begin
    readdata = '0;
    if (ctrl_sel) begin
      readdata = {29'b0, irq_en_rd, 1'b0, imm};
    end else if (status_sel) begin
      readdata = {30'b0, done, pending};
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (shadow_sel[k]) begin
          readdata = 32'(shadow[k]);
        end
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_out
    assign out_port[g*WIDTH +: WIDTH] = live[g];
  end

endmodule

// File: tb/tb_vga_pio_dbuf.sv
// -----------------------------------------------------------------------------
// tb_vga_pio_dbuf
//   Directed bench for vga_pio_dbuf with default parameters (WIDTH=24, N_CH=4,
//   ADDR_W=4, RESET_VAL=0). Expected values are pushed to exp_q as each step is
//   driven and popped when the DUT output is sampled (on the falling edge).
// -----------------------------------------------------------------------------
module tb_vga_pio_dbuf;

  localparam int WIDTH  = 24;
  localparam int N_CH   = 4;
  localparam int ADDR_W = 4;
  localparam int W      = N_CH * WIDTH;

`ifdef VGA_PIO_DBUF_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic              frame_sync = 1'b0;
  logic [W-1:0]      out_port;
  logic              irq;

  always #5 clk = ~clk;

  vga_pio_dbuf #(
    .WIDTH(WIDTH), .N_CH(N_CH), .ADDR_W(ADDR_W), .RESET_VAL(32'd0)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .frame_sync(frame_sync), .out_port(out_port), .irq(irq)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic expect_val(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h but no expected value queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  function automatic logic [W-1:0] chans(input logic [23:0] c0, input logic [23:0] c1,
                                         input logic [23:0] c2, input logic [23:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  // ---------------- driver tasks ----------------
  // One write, performed at the rising edge after the next falling edge.
  // Returns on the falling edge after that write edge.
  task automatic bus_write(input int a, input logic [31:0] d);
    @(negedge clk);
    address    = ADDR_W'(a);
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Combinational read, no clock edge consumed.
  task automatic bus_read(input int a, output logic [31:0] d);
    address = ADDR_W'(a);
    #1;
    d = readdata;
  endtask

  task automatic check_reg(input string tag, input int a, input logic [31:0] e);
    logic [31:0] d;
    expect_val(W'(e));
    bus_read(a, d);
    check(tag, W'(d));
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] e);
    expect_val(e);
    check(tag, out_port);
  endtask

  task automatic check_irq(input string tag, input logic e);
    expect_val(W'(e));
    check(tag, W'(irq));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check_out("rst_out", '0);
    check_reg("rst_status", 1, 32'h0);
    check_reg("rst_ctrl", 0, 32'h0);
    for (int k = 0; k < N_CH; k++) check_reg($sformatf("rst_shadow%0d", k), k + 2, 32'h0);
    check_irq("rst_irq", 1'b0);
    check_reg("unmapped_rd", 9, 32'h0);

    // Frame-synchronous commit
    bus_write(2, 32'hFF0000);
    bus_write(3, 32'h00FF00);
    check_out("fs_hold_out", '0);
    check_reg("fs_pending", 1, 32'h1);
    @(negedge clk);
    frame_sync = 1'b1;
    @(negedge clk);
    check_out("fs_commit_out", chans(24'hFF0000, 24'h00FF00, 0, 0));
    check_reg("fs_commit_status", 1, 32'h2);

    // frame_sync held high: no further commits
    bus_write(2, 32'h111111);
    repeat (3) @(negedge clk);
    check_out("fs_held_out", chans(24'hFF0000, 24'h00FF00, 0, 0));
    check_reg("fs_held_status", 1, 32'h3);
    bus_write(0, 32'h2);
    check_out("force_out", chans(24'h111111, 24'h00FF00, 0, 0));
    frame_sync = 1'b0;
    bus_write(1, 32'h2);
    check_reg("done_clear", 1, 32'h0);
    bus_write(12, 32'hFFFFFF);
    check_out("unmapped_wr", chans(24'h111111, 24'h00FF00, 0, 0));

    // Immediate mode
    bus_write(0, 32'h1);
    check_reg("imm_ctrl", 0, 32'h1);
    bus_write(4, 32'h123456);
    check_out("imm_out", chans(24'h111111, 24'h00FF00, 24'h123456, 0));
    check_reg("imm_status", 1, 32'h0);
    bus_write(0, 32'h0);

    // Write in the same cycle as fs_rise
    bus_write(2, 32'h222222);
    check_out("pend_out", chans(24'h111111, 24'h00FF00, 24'h123456, 0));
    @(negedge clk);
    frame_sync = 1'b1;
    address    = ADDR_W'(2);
    writedata  = 32'hABCDEF;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    check_out("race_out", chans(24'h222222, 24'h00FF00, 24'h123456, 0));
    check_reg("race_shadow0", 2, 32'hABCDEF);
    check_reg("race_status", 1, 32'h3);
    bus_write(0, 32'h2);
    check_out("race_force_out", chans(24'hABCDEF, 24'h00FF00, 24'h123456, 0));
    check_reg("race_force_status", 1, 32'h2);
    frame_sync = 1'b0;

    // DONE clear in the same cycle as a commit: set wins
    bus_write(3, 32'h333333);
    @(negedge clk);
    frame_sync = 1'b1;
    address    = ADDR_W'(1);
    writedata  = 32'h2;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    check_out("clr_race_out", chans(24'hABCDEF, 24'h333333, 24'h123456, 0));
    check_reg("clr_race_status", 1, 32'h2);
    frame_sync = 1'b0;

    // IMM 0 -> 1 while pending: no commit
    bus_write(2, 32'h444444);
    bus_write(0, 32'h1);
    check_out("imm_sw_out", chans(24'hABCDEF, 24'h333333, 24'h123456, 0));
    check_reg("imm_sw_status", 1, 32'h3);
    bus_write(0, 32'h2);
    check_out("imm_sw_force", chans(24'h444444, 24'h333333, 24'h123456, 0));

    // FORCE with nothing pending
    bus_write(1, 32'h2);
    bus_write(0, 32'h2);
    check_out("force_idle_out", chans(24'h444444, 24'h333333, 24'h123456, 0));
    check_reg("force_idle_status", 1, 32'h0);

    // Reset while pending
    bus_write(4, 32'h555555);
    check_reg("pre_rst_status", 1, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_out("rst2_out", '0);
    check_reg("rst2_status", 1, 32'h0);
    check_reg("rst2_shadow2", 4, 32'h0);
    check_reg("rst2_ctrl", 0, 32'h0);

    // Interrupt
    bus_write(0, 32'h4);
    check_reg("irq_ctrl", 0, IRQ_ON ? 32'h4 : 32'h0);
    bus_write(2, 32'h666666);
    bus_write(0, 32'h6);
    check_out("irq_force_out", chans(24'h666666, 0, 0, 0));
    check_irq("irq_1cyc", 1'b0);
    @(negedge clk);
    check_irq("irq_2cyc", IRQ_ON);
    bus_write(1, 32'h2);
    check_irq("irq_clr_edge", IRQ_ON);
    @(negedge clk);
    check_irq("irq_cleared", 1'b0);
    check_reg("irq_status", 1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
